// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: md_op encodings and default
// busy-cycle counts.
package mdu_defs;

  typedef enum logic [3:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMthi  = 4'd5,
    MdMtlo  = 4'd6,
    MdMfhi  = 4'd7,
    MdMflo  = 4'd8
  } md_op_e;

  localparam int unsigned MduMultCycles = 5;
  localparam int unsigned MduDivCycles  = 10;

endpackage

// File: rtl/mdu_execute_divider.sv
// Signed/unsigned 32-bit restoring divider, fully unrolled (32 shift-subtract steps).
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module mdu_divider (
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        neg_a, neg_b;
  logic [31:0] abs_a, abs_b, quo;
  logic [32:0] rem;

  always_comb begin
    neg_a = signed_i & dividend_i[31];
    neg_b = signed_i & divisor_i[31];
    abs_a = neg_a ? (32'd0 - dividend_i) : dividend_i;
    abs_b = neg_b ? (32'd0 - divisor_i) : divisor_i;
    rem   = '0;
    quo   = abs_a;
    for (int i = 0; i < 32; i++) begin
      rem = {rem[31:0], quo[31]};
      quo = {quo[30:0], 1'b0};
      if (rem >= {1'b0, abs_b}) begin
        rem    = rem - {1'b0, abs_b};
        quo[0] = 1'b1;
      end
    end
    // 0x80000000 / -1 wraps back to 0x80000000 through this negation, which is intended.
    quotient_o  = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
    remainder_o = neg_a ? (32'd0 - rem[31:0]) : rem[31:0];
  end

endmodule

// File: rtl/mdu_execute.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div for a fixed number of busy
// cycles and commits the precomputed result on the completion edge.
module mdu_execute
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MduMultCycles,
  parameter int unsigned DIV_CYCLES  = MduDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_result
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;
  logic              is_mul, is_div;
  logic [63:0]       prod_s, prod_u;
  logic [31:0]       div_q, div_r;

  assign is_mul = (md_op == MdMult) || (md_op == MdMultu);
  assign is_div = (md_op == MdDiv) || (md_op == MdDivu);

  // Low 64 bits of the sign-/zero-extended products equal the 32x32 signed/unsigned product.
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  mdu_divider u_divider (
    .dividend_i  (src_a),
    .divisor_i   (src_b),
    .signed_i    (md_op == MdDiv),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && (is_mul || is_div)) state_d = StRun;
      StRun:   if (cnt_q == CntW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (state_q == StIdle && start) begin
      case (md_op)
        MdMult: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = CntW'(MULT_CYCLES);
        end
        MdMultu: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = CntW'(MULT_CYCLES);
        end
        MdDiv, MdDivu: begin
          pend_hi_d = div_r;
          pend_lo_d = div_q;
          // Divide by zero still occupies the unit but leaves HI/LO untouched.
          pend_wr_d = (src_b != 32'd0);
          cnt_d     = CntW'(DIV_CYCLES);
        end
        MdMthi:  hi_d = src_a;
        MdMtlo:  lo_d = src_a;
        default: ;
      endcase
    end else if (state_q == StRun) begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        pend_wr_d = 1'b0;
      end
    end
  end

  always_comb begin
    case (md_op)
      MdMfhi:  md_result = hi_q;
      MdMflo:  md_result = lo_q;
      default: md_result = 32'd0;
    endcase
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_execute.sv
// Bench for mdu_execute: directed vector table, mid-flight intrusion and reset sequences,
// then random ops checked against an arithmetic reference model.
module tb_mdu_execute;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy;
  logic [31:0] hi, lo, md_result;

  int unsigned n_total = 0, n_pass = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu_execute #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .md_result (md_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Called at a negedge with start low; returns at the negedge after busy has fallen.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input logic [3:0] intr_op, input int intr_at);
    int cyc;
    md_op = op; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MdNone;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 1) begin
        chk({name, " hi_old"}, hi, m_hi);
        chk({name, " lo_old"}, lo, m_lo);
      end
      if (cyc == intr_at) begin
        start = 1'b1; md_op = intr_op; src_a = 32'h5555_5555; src_b = 32'h3;
      end else begin
        start = 1'b0; md_op = MdNone;
      end
      @(negedge clk);
    end
    start = 1'b0; md_op = MdNone;
    chk({name, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({name, " hi"}, hi, exp_hi);
    chk({name, " lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  // Reference model: plain SV arithmetic on 64-bit values.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p, q, r;
    rh = m_hi; rl = m_lo; cyc = 0;
    case (op)
      MdMult: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        rh = p[63:32]; rl = p[31:0]; cyc = 5;
      end
      MdMultu: begin
        p = 64'(a) * 64'(b);
        rh = p[63:32]; rl = p[31:0]; cyc = 5;
      end
      MdDiv: begin
        cyc = 10;
        if (b != 0) begin
          q = 64'(longint'($signed(a)) / longint'($signed(b)));
          r = 64'(longint'($signed(a)) % longint'($signed(b)));
          rh = r[31:0]; rl = q[31:0];
        end
      end
      MdDivu: begin
        cyc = 10;
        if (b != 0) begin
          rh = a % b; rl = a / b;
        end
      end
      MdMthi: rh = a;
      MdMtlo: rl = a;
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    int          e_cyc;
    logic [31:0] e_hi, e_lo, ra, rb;
    logic [3:0]  rop;

    vecs[0] = '{MdMult,  32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{MdMultu, 32'hFFFF_FFFE, 32'd3,        5,  32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{MdDiv,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MdMthi,  32'h0000_0011, 32'd0,        0,  32'h0000_0011, 32'hFFFF_FFFD};
    vecs[4] = '{MdMtlo,  32'h0000_0022, 32'd0,        0,  32'h0000_0011, 32'h0000_0022};
    vecs[5] = '{MdDivu,  32'd7,         32'd0,        10, 32'h0000_0011, 32'h0000_0022};
    vecs[6] = '{MdDiv,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{MdDivu,  32'hFFFF_FFFF, 32'h10,       10, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[8] = '{MdDiv,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{MdMthi,  32'hDEAD_BEEF, 32'd0,        0,  32'hDEAD_BEEF, 32'hFFFF_FFFD};

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc,
            vecs[i].hi, vecs[i].lo, MdNone, 0);

    // Zero-latency reads; MF*/NONE starts must not disturb state.
    md_op = MdMfhi; start = 1'b1;
    #1 chk("mfhi result", md_result, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("mfhi busy", 32'(busy), 32'd0);
    md_op = MdMflo;
    #1 chk("mflo result", md_result, 32'hFFFF_FFFD);
    @(negedge clk);
    md_op = MdNone;
    #1 chk("none result", md_result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("mf hi kept", hi, 32'hDEAD_BEEF);
    chk("mf lo kept", lo, 32'hFFFF_FFFD);

    // Starts arriving while busy are ignored, including on the completion edge.
    do_op("intr mthi", MdDivu, 32'd100, 32'd7, 10, 32'd2, 32'd14, MdMthi, 2);
    do_op("intr mult", MdMult, 32'd9, 32'd9, 5, 32'd0, 32'd81, MdMult, 5);
    do_op("intr mtlo", MdMultu, 32'd4, 32'd4, 5, 32'd0, 32'd16, MdMtlo, 1);

    // Reset mid-divide after an ignored MTLO.
    do_op("pre hi", MdMthi, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'd16, MdNone, 0);
    md_op = MdDiv; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MdNone;
    @(negedge clk);
    md_op = MdMtlo; src_a = 32'h7777_7777; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MdNone;
    chk("mtlo ignored lo", lo, 32'd16);
    chk("mtlo busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("post abort busy", 32'(busy), 32'd0);
    chk("post abort hi", hi, 32'd0);
    chk("post abort lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    do_op("mult after reset", MdMult, 32'd2, 32'd3, 5, 32'd0, 32'd6, MdNone, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 10 == 3) rb = rb & 32'hFF;
      model(rop, ra, rb, e_cyc, e_hi, e_lo);
      do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, e_cyc, e_hi, e_lo, MdNone, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
